// File: rtl/tone_sequencer.sv
// tone_sequencer
//   Plays a short melody by sequencing the maxcount input of the speaker
//   clock divider. A writable note table holds {tone maxcount, duration in
//   ticks}. A start plays the first len entries in order, optionally
//   looping. maxcount is 0 (silence) whenever the block is idle.
//
//   Optional build macro: NOTE_GAP_EN
//     Defined: GAP_TICKS silent ticks follow every note.
//     Undefined: notes run back-to-back with only the one-cycle LOAD
//     between them.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   start         level; starts playback from entry 0 when idle
//   stop          aborts playback; wins over start
//   loop          sampled at the end of the last note; 1 restarts at entry 0
//   len           entries to play (0..DEPTH); latched when start is accepted
//   wr_en/wr_addr/wr_maxcount/wr_dur   note-table write port
//   maxcount      registered tone value to the divider (0 = silence)
//   busy          high in any non-IDLE state
//   note_idx      entry currently loaded or playing
//   done          one-cycle pulse when a non-looping sequence completes
module tone_sequencer #(
    parameter int DEPTH     = 16,
    parameter int DUR_W     = 12,
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int GAP_TICKS = 20,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W:0]   len,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_maxcount,
    input  logic [DUR_W-1:0]  wr_dur,
    output logic [15:0]       maxcount,
    output logic              busy,
    output logic [ADDR_W-1:0] note_idx,
    output logic              done
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] PLAY = 2'd2;
`ifdef NOTE_GAP_EN
    localparam logic [1:0] GAP  = 2'd3;
`endif

    typedef struct packed {
        logic [15:0]      tone;
        logic [DUR_W-1:0] dur;
    } note_t;

    note_t             tbl [DEPTH];
    note_t             cur;
    logic [1:0]        state;
    logic [PW-1:0]     presc;
    logic [DUR_W-1:0]  dur_cnt;
    logic [ADDR_W:0]   len_q;
    logic              tick;
    logic              last;
    logic [1:0]        adv_state;
    logic [ADDR_W-1:0] adv_idx;
    logic              adv_done;

    // Table is flop-based so reset can clear every entry. LOAD reads the
    // current register value, so a same-cycle write to the loaded address
    // is seen only on a later pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else if (wr_en) begin
            tbl[wr_addr] <= '{tone: wr_maxcount, dur: wr_dur};
        end
    end

    assign cur  = tbl[note_idx];
    assign busy = (state != IDLE);
    assign tick = (presc == PRESC_MAX);
    assign last = ({1'b0, note_idx} == (len_q - (ADDR_W+1)'(1)));

    // Where to go once a note (or its trailing gap) has finished.
    always_comb begin
        adv_state = LOAD;
        adv_idx   = note_idx + ADDR_W'(1);
        adv_done  = 1'b0;
        if (last) begin
            adv_idx = '0;
            if (!loop) begin
                adv_state = IDLE;
                adv_done  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            maxcount <= '0;
            note_idx <= '0;
            done     <= 1'b0;
            presc    <= '0;
            dur_cnt  <= '0;
            len_q    <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                maxcount <= '0;
                note_idx <= '0;
                presc    <= '0;
                dur_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        maxcount <= '0;
                        presc    <= '0;
                        if (start && (len != '0)) begin
                            len_q    <= len;
                            note_idx <= '0;
                            state    <= LOAD;
                        end
                    end
                    LOAD: begin
                        // maxcount of the previous note is held through
                        // this cycle; the prescaler restarts so the first
                        // tick lands exactly DIV cycles from here.
                        maxcount <= cur.tone;
                        dur_cnt  <= (cur.dur == '0) ? DUR_W'(1) : cur.dur;
                        presc    <= '0;
                        state    <= PLAY;
                    end
                    PLAY: begin
                        presc <= tick ? '0 : presc + PW'(1);
                        if (tick) begin
                            if (dur_cnt == DUR_W'(1)) begin
`ifdef NOTE_GAP_EN
                                state    <= GAP;
                                maxcount <= '0;
                                dur_cnt  <= DUR_W'(GAP_TICKS);
`else
                                state    <= adv_state;
                                note_idx <= adv_idx;
                                done     <= adv_done;
                                if (adv_done) maxcount <= '0;
`endif
                            end else begin
                                dur_cnt <= dur_cnt - DUR_W'(1);
                            end
                        end
                    end
`ifdef NOTE_GAP_EN
                    GAP: begin
                        maxcount <= '0;
                        presc    <= tick ? '0 : presc + PW'(1);
                        if (tick) begin
                            if (dur_cnt <= DUR_W'(1)) begin
                                state    <= adv_state;
                                note_idx <= adv_idx;
                                done     <= adv_done;
                            end else begin
                                dur_cnt <= dur_cnt - DUR_W'(1);
                            end
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer at 10 clk per tick.
// Outputs are sampled on the falling edge as {maxcount, busy, note_idx, done}.
// Sample k is the k-th falling edge after the one where start was driven.
module tb_tone_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, loop;
    logic [4:0]  len;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_maxcount;
    logic [11:0] wr_dur;
    logic [15:0] maxcount;
    logic        busy;
    logic [3:0]  note_idx;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    tone_sequencer #(
        .DEPTH(16), .DUR_W(12), .CLK_HZ(100), .TICK_HZ(10), .GAP_TICKS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
        .len(len), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_maxcount(wr_maxcount), .wr_dur(wr_dur),
        .maxcount(maxcount), .busy(busy), .note_idx(note_idx), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] pk(input int mc, input bit b, input int idx, input bit d);
        logic [15:0] m;
        logic [3:0]  i;
        m = mc[15:0];
        i = idx[3:0];
        return {m, b, i, d};
    endfunction

    task automatic write_entry(input int a, input int mc, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a[3:0]; wr_maxcount = mc[15:0]; wr_dur = d[11:0];
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic go_idle;
        @(negedge clk);
        stop = 1'b1; start = 1'b0;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_reset;
        logic [21:0] obs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        obs = {maxcount, busy, note_idx, done};
        n_tests++;
        if (obs !== pk(0, 0, 0, 0)) begin
            n_fail++; $display("FAIL reset_state got %h want %h", obs, pk(0, 0, 0, 0));
        end
        rst_n = 1'b1;
    endtask

`ifndef NOTE_GAP_EN
    task automatic test_basic;
        logic [21:0] obs, exp;
        bit chk;
        int dn = 0;
        write_entry(0, 1000, 2);
        write_entry(1, 0, 1);
        write_entry(2, 500, 3);
        len = 5'd3; loop = 1'b0; start = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) dn++;
            obs = {maxcount, busy, note_idx, done};
            chk = 1'b1;
            case (k)
                1:  exp = pk(0, 1, 0, 0);
                2:  exp = pk(1000, 1, 0, 0);
                22: exp = pk(1000, 1, 1, 0);
                23: exp = pk(0, 1, 1, 0);
                33: exp = pk(0, 1, 2, 0);
                34: exp = pk(500, 1, 2, 0);
                63: exp = pk(500, 1, 2, 0);
                64: exp = pk(0, 0, 0, 1);
                65: exp = pk(0, 0, 0, 0);
                default: chk = 1'b0;
            endcase
            if (chk) begin
                n_tests++;
                if (obs !== exp) begin
                    n_fail++; $display("FAIL basic_k%0d got %h want %h", k, obs, exp);
                end
            end
        end
        n_tests++;
        if (dn != 1) begin
            n_fail++; $display("FAIL basic_done_count got %0d want 1", dn);
        end
    endtask

    task automatic test_loop_stop;
        logic [21:0] obs, exp;
        bit chk;
        int dn = 0;
        len = 5'd3; loop = 1'b1; start = 1'b1;
        for (int k = 1; k <= 73; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) dn++;
            obs = {maxcount, busy, note_idx, done};
            chk = 1'b1;
            case (k)
                63: exp = pk(500, 1, 2, 0);
                64: exp = pk(500, 1, 0, 0);
                65: exp = pk(1000, 1, 0, 0);
                70: exp = pk(1000, 1, 0, 0);
                71: exp = pk(0, 0, 0, 0);
                72: exp = pk(0, 0, 0, 0);
                73: exp = pk(0, 0, 0, 0);
                default: chk = 1'b0;
            endcase
            if (chk) begin
                n_tests++;
                if (obs !== exp) begin
                    n_fail++; $display("FAIL loop_stop_k%0d got %h want %h", k, obs, exp);
                end
            end
            if (k == 70) stop = 1'b1;
            if (k == 71) start = 1'b1;
            if (k == 72) begin stop = 1'b0; start = 1'b0; end
        end
        n_tests++;
        if (dn != 0) begin
            n_fail++; $display("FAIL loop_done_count got %0d want 0", dn);
        end
        loop = 1'b0;
    endtask

    task automatic test_len_zero;
        logic [21:0] obs;
        len = 5'd0; start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            obs = {maxcount, busy, note_idx, done};
            if (k == 1 || k == 3) begin
                n_tests++;
                if (obs !== pk(0, 0, 0, 0)) begin
                    n_fail++; $display("FAIL len_zero_k%0d got %h want %h", k, obs, pk(0, 0, 0, 0));
                end
            end
        end
    endtask

    task automatic test_dur_zero;
        logic [21:0] obs, exp;
        bit chk;
        write_entry(0, 700, 0);
        len = 5'd1; loop = 1'b0; start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            obs = {maxcount, busy, note_idx, done};
            chk = 1'b1;
            case (k)
                1:  exp = pk(0, 1, 0, 0);
                2:  exp = pk(700, 1, 0, 0);
                11: exp = pk(700, 1, 0, 0);
                12: exp = pk(0, 0, 0, 1);
                default: chk = 1'b0;
            endcase
            if (chk) begin
                n_tests++;
                if (obs !== exp) begin
                    n_fail++; $display("FAIL dur_zero_k%0d got %h want %h", k, obs, exp);
                end
            end
        end
    endtask

    task automatic test_write_during_play;
        logic [21:0] obs, exp;
        bit chk;
        write_entry(0, 1000, 2);
        write_entry(1, 0, 1);
        write_entry(2, 500, 3);
        len = 5'd3; loop = 1'b1; start = 1'b1;
        for (int k = 1; k <= 76; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            obs = {maxcount, busy, note_idx, done};
            chk = 1'b1;
            case (k)
                10: exp = pk(1000, 1, 0, 0);
                23: exp = pk(0, 1, 1, 0);
                65: exp = pk(300, 1, 0, 0);
                75: exp = pk(300, 1, 1, 0);
                76: exp = pk(900, 1, 1, 0);
                default: chk = 1'b0;
            endcase
            if (chk) begin
                n_tests++;
                if (obs !== exp) begin
                    n_fail++; $display("FAIL wr_play_k%0d got %h want %h", k, obs, exp);
                end
            end
            if (k == 5) begin
                wr_en = 1'b1; wr_addr = 4'd0; wr_maxcount = 16'd300; wr_dur = 12'd1;
            end
            if (k == 22) begin
                wr_en = 1'b1; wr_addr = 4'd1; wr_maxcount = 16'd900; wr_dur = 12'd1;
            end
            if (k == 6 || k == 23) wr_en = 1'b0;
        end
        loop = 1'b0;
        go_idle();
    endtask
`else
    task automatic test_gap;
        logic [21:0] obs, exp;
        bit chk;
        int dn = 0;
        write_entry(0, 1000, 2);
        write_entry(1, 0, 1);
        write_entry(2, 500, 3);
        len = 5'd3; loop = 1'b0; start = 1'b1;
        for (int k = 1; k <= 126; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) dn++;
            obs = {maxcount, busy, note_idx, done};
            chk = 1'b1;
            case (k)
                21:  exp = pk(1000, 1, 0, 0);
                22:  exp = pk(0, 1, 0, 0);
                41:  exp = pk(0, 1, 0, 0);
                42:  exp = pk(0, 1, 1, 0);
                73:  exp = pk(0, 1, 2, 0);
                74:  exp = pk(500, 1, 2, 0);
                103: exp = pk(500, 1, 2, 0);
                104: exp = pk(0, 1, 2, 0);
                123: exp = pk(0, 1, 2, 0);
                124: exp = pk(0, 0, 0, 1);
                default: chk = 1'b0;
            endcase
            if (chk) begin
                n_tests++;
                if (obs !== exp) begin
                    n_fail++; $display("FAIL gap_k%0d got %h want %h", k, obs, exp);
                end
            end
        end
        n_tests++;
        if (dn != 1) begin
            n_fail++; $display("FAIL gap_done_count got %0d want 1", dn);
        end
    endtask
`endif

    task automatic test_reset_mid;
        logic [21:0] obs;
        write_entry(0, 1000, 2);
        len = 5'd1; loop = 1'b0; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        obs = {maxcount, busy, note_idx, done};
        n_tests++;
        if (obs !== pk(1000, 1, 0, 0)) begin
            n_fail++; $display("FAIL rst_mid_pre got %h want %h", obs, pk(1000, 1, 0, 0));
        end
        #2 rst_n = 1'b0;
        #1;
        obs = {maxcount, busy, note_idx, done};
        n_tests++;
        if (obs !== pk(0, 0, 0, 0)) begin
            n_fail++; $display("FAIL rst_mid_async got %h want %h", obs, pk(0, 0, 0, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        // Entry 0 was cleared, so the replayed note is a rest.
        obs = {maxcount, busy, note_idx, done};
        n_tests++;
        if (obs !== pk(0, 1, 0, 0)) begin
            n_fail++; $display("FAIL rst_mid_table_cleared got %h want %h", obs, pk(0, 1, 0, 0));
        end
        go_idle();
    endtask

    initial begin
        start = 1'b0; stop = 1'b0; loop = 1'b0; len = '0;
        wr_en = 1'b0; wr_addr = '0; wr_maxcount = '0; wr_dur = '0;
        test_reset();
`ifndef NOTE_GAP_EN
        test_basic();
        test_loop_stop();
        test_len_zero();
        test_dur_zero();
        test_write_during_play();
`else
        test_gap();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
